// File: rtl/raytrace_lane_scheduler_if.sv
// Handshake and data bundle between the frame scheduler, its raytracing lanes and the framebuffer writer.
// master = scheduler side, slave = environment (executor, lanes, framebuffer).
interface raytrace_lane_scheduler_if #(
    parameter int NUM_LANES = 4,
    parameter int X_WIDTH   = 9,
    parameter int Y_WIDTH   = 8,
    parameter int PIX_WIDTH = 16
);
    logic                           frame_start;
    logic                           frame_abort;
    logic                           busy;
    logic                           frame_done;
    logic                           lane_flush;
    logic [NUM_LANES-1:0]           lane_ready;
    logic [NUM_LANES-1:0]           lane_issue_valid;
    logic [X_WIDTH-1:0]             lane_issue_x;
    logic [Y_WIDTH-1:0]             lane_issue_y;
    logic [NUM_LANES-1:0]           lane_result_valid;
    logic [NUM_LANES*PIX_WIDTH-1:0] lane_result_pixel;
    logic                           out_valid;
    logic                           out_ready;
    logic [X_WIDTH-1:0]             out_x;
    logic [Y_WIDTH-1:0]             out_y;
    logic [PIX_WIDTH-1:0]           out_pixel;
    logic                           protocol_error;

    modport master (
        input  frame_start, frame_abort, lane_ready, lane_result_valid, lane_result_pixel, out_ready,
        output busy, frame_done, lane_flush, lane_issue_valid, lane_issue_x, lane_issue_y,
               out_valid, out_x, out_y, out_pixel, protocol_error
    );

    modport slave (
        output frame_start, frame_abort, lane_ready, lane_result_valid, lane_result_pixel, out_ready,
        input  busy, frame_done, lane_flush, lane_issue_valid, lane_issue_x, lane_issue_y,
               out_valid, out_x, out_y, out_pixel, protocol_error
    );
endinterface

// File: rtl/raytrace_lane_scheduler.sv
// Round-robin pixel job issue across lanes, results re-serialised into raster order.
// Latency: result captured at edge t is presented on out_* from cycle t+1; issue is combinational on lane_ready.
// Backpressure: out_ready low holds out_* stable; issue stalls once the current lane's slot is not FREE.
module raytrace_lane_scheduler #(
    parameter int NUM_LANES     = 4,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int X_WIDTH       = 9,
    parameter int Y_WIDTH       = 8,
    parameter int PIX_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst,
    raytrace_lane_scheduler_if.master bus
);
    localparam int LW = $clog2(NUM_LANES);
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_BUSY, SLOT_FULL} slot_t;

    state_t               state_q, state_d;
    slot_t                slot_q [NUM_LANES];
    slot_t                slot_d [NUM_LANES];
    logic [PIX_WIDTH-1:0] pix_q  [NUM_LANES];
    logic [LW-1:0]        ip_q, dp_q;
    logic [X_WIDTH-1:0]   ix_q, ox_q;
    logic [Y_WIDTH-1:0]   iy_q, oy_q;
    logic                 perr_q;

    logic                 abort_evt, start_evt, issue_fire, out_vld, drain_fire;
    logic                 last_issue, last_out;
    logic [NUM_LANES-1:0] res_take, stray;

    // Abort wins over everything in its cycle, so it masks issue and drain as well.
    assign abort_evt  = bus.frame_abort && (state_q != S_IDLE);
    assign start_evt  = bus.frame_start && (state_q == S_IDLE);
    assign issue_fire = (state_q == S_RUN) && !abort_evt &&
                        (slot_q[ip_q] == SLOT_FREE) && bus.lane_ready[ip_q];
    assign out_vld    = !abort_evt && (slot_q[dp_q] == SLOT_FULL);
    assign drain_fire = out_vld && bus.out_ready;
    assign last_issue = (ix_q == X_LAST) && (iy_q == Y_LAST);
    assign last_out   = (ox_q == X_LAST) && (oy_q == Y_LAST);

    assign bus.busy             = (state_q != S_IDLE);
    assign bus.frame_done       = (state_q == S_DONE);
    assign bus.lane_flush       = abort_evt;
    assign bus.lane_issue_valid = issue_fire ? (NUM_LANES'(1) << ip_q) : '0;
    assign bus.lane_issue_x     = ix_q;
    assign bus.lane_issue_y     = iy_q;
    assign bus.out_valid        = out_vld;
    assign bus.out_x            = ox_q;
    assign bus.out_y            = oy_q;
    assign bus.out_pixel        = pix_q[dp_q];
    assign bus.protocol_error   = perr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_evt) state_d = S_RUN;
            S_RUN:   if (issue_fire && last_issue) state_d = S_FLUSH;
            S_FLUSH: if (drain_fire && last_out) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_evt) state_d = S_IDLE;
    end

    // Per-slot transitions are mutually exclusive because each keys off a different current state.
    always_comb begin
        res_take = '0;
        stray    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            slot_d[i] = slot_q[i];
            if ((state_q != S_IDLE) && bus.lane_result_valid[i]) begin
                if (slot_q[i] == SLOT_BUSY) res_take[i] = 1'b1;
                else                        stray[i]    = 1'b1;
            end
            if (issue_fire && (ip_q == LW'(i)))  slot_d[i] = SLOT_BUSY;
            if (res_take[i])                     slot_d[i] = SLOT_FULL;
            if (drain_fire && (dp_q == LW'(i)))  slot_d[i] = SLOT_FREE;
            if (abort_evt || start_evt)          slot_d[i] = SLOT_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ip_q    <= '0;
            dp_q    <= '0;
            ix_q    <= '0;
            iy_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            perr_q  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                slot_q[i] <= SLOT_FREE;
                pix_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                slot_q[i] <= slot_d[i];
                if (res_take[i] && !abort_evt)
                    pix_q[i] <= bus.lane_result_pixel[i*PIX_WIDTH +: PIX_WIDTH];
            end
            if (|stray && !abort_evt)
                perr_q <= 1'b1;
            if (start_evt || abort_evt) begin
                ip_q <= '0;
                dp_q <= '0;
                ix_q <= '0;
                iy_q <= '0;
                ox_q <= '0;
                oy_q <= '0;
            end else begin
                if (issue_fire) begin
                    ip_q <= ip_q + LW'(1);
                    ix_q <= (ix_q == X_LAST) ? '0 : ix_q + X_WIDTH'(1);
                    if (ix_q == X_LAST)
                        iy_q <= (iy_q == Y_LAST) ? '0 : iy_q + Y_WIDTH'(1);
                end
                if (drain_fire) begin
                    dp_q <= dp_q + LW'(1);
                    ox_q <= (ox_q == X_LAST) ? '0 : ox_q + X_WIDTH'(1);
                    if (ox_q == X_LAST)
                        oy_q <= (oy_q == Y_LAST) ? '0 : oy_q + Y_WIDTH'(1);
                end
            end
        end
    end
endmodule
